// File: rtl/seven_segment_scan_driver.sv
// ============================================================================
// seven_segment_scan_driver
//   Time-multiplexed common-anode seven-segment scanner with frame-aligned,
//   double-buffered updates and leading-zero blanking.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit HEX_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_suppress,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  digit_tick,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int c_cnt_w = $clog2(REFRESH_DIV);
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_act_value, r_sh_value;
  logic [DIGITS-1:0]   r_act_dp, r_sh_dp;
  logic [DIGITS-1:0]   r_act_blank, r_sh_blank;
  logic                r_act_lz, r_sh_lz;
  logic                r_pending;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;
  logic                r_digit_tick, r_frame_tick;

  logic                w_slot_edge, w_frame_edge;
  logic [c_idx_w-1:0]  w_next_idx;
  logic [4*DIGITS-1:0] w_eff_value;
  logic [DIGITS-1:0]   w_eff_dp, w_eff_blank;
  logic                w_eff_lz;
  logic [3:0]          w_nib;
  logic                w_dp, w_blank, w_sel_zero, w_run, w_lz_hide;
  logic [DIGITS-1:0]   w_an_next;
  logic [6:0]          w_glyph;
  logic [7:0]          w_seg_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = HEX_EN ? 7'b0001000 : 7'b1111111;
      4'hB: g = HEX_EN ? 7'b1100000 : 7'b1111111;
      4'hC: g = HEX_EN ? 7'b0110001 : 7'b1111111;
      4'hD: g = HEX_EN ? 7'b1000010 : 7'b1111111;
      4'hE: g = HEX_EN ? 7'b0110000 : 7'b1111111;
      default: g = HEX_EN ? 7'b0111000 : 7'b1111111;
    endcase
    return g;
  endfunction

  assign w_slot_edge  = (r_cnt == c_last_cnt);
  assign w_frame_edge = w_slot_edge && (r_idx == c_last_idx);
  assign w_next_idx   = (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);

  // Data the active register will hold after this edge; outputs are decoded
  // from it so a frame-edge commit is visible on the same edge.
  always_comb begin
    w_eff_value = r_act_value;
    w_eff_dp    = r_act_dp;
    w_eff_blank = r_act_blank;
    w_eff_lz    = r_act_lz;
    if (w_frame_edge && load) begin
      w_eff_value = value_in;
      w_eff_dp    = dp_in;
      w_eff_blank = blank_in;
      w_eff_lz    = lz_suppress;
    end else if (w_frame_edge && r_pending) begin
      w_eff_value = r_sh_value;
      w_eff_dp    = r_sh_dp;
      w_eff_blank = r_sh_blank;
      w_eff_lz    = r_sh_lz;
    end
  end

  // Walk from the most significant digit down so w_run tracks "this nibble
  // and all higher nibbles are zero" for the selected digit.
  always_comb begin
    w_nib      = 4'd0;
    w_dp       = 1'b0;
    w_blank    = 1'b0;
    w_sel_zero = 1'b0;
    w_an_next  = '1;
    w_run      = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run = w_run && (w_eff_value[4*k +: 4] == 4'd0);
      if (w_next_idx == c_idx_w'(k)) begin
        w_nib        = w_eff_value[4*k +: 4];
        w_dp         = w_eff_dp[k];
        w_blank      = w_eff_blank[k];
        w_sel_zero   = w_run;
        w_an_next[k] = 1'b0;
      end
    end
  end

  assign w_lz_hide  = w_eff_lz && (w_next_idx != '0) && w_sel_zero;
  assign w_glyph    = w_lz_hide ? 7'h7F : decode(w_nib);
  assign w_seg_next = w_blank ? 8'hFF : {w_glyph, ~w_dp};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= c_last_idx;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_act_lz     <= 1'b0;
      r_sh_value   <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_sh_lz      <= 1'b0;
      r_pending    <= 1'b0;
      r_an         <= '1;
      r_seg        <= 8'hFF;
      r_digit_tick <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_digit_tick <= w_slot_edge;
      r_frame_tick <= w_frame_edge;
      r_cnt        <= w_slot_edge ? '0 : r_cnt + c_cnt_w'(1);
      if (w_slot_edge) begin
        r_idx <= w_next_idx;
        r_an  <= w_an_next;
        r_seg <= w_seg_next;
      end
      if (w_frame_edge) begin
        r_act_value <= w_eff_value;
        r_act_dp    <= w_eff_dp;
        r_act_blank <= w_eff_blank;
        r_act_lz    <= w_eff_lz;
        r_pending   <= 1'b0;
      end else if (load) begin
        r_sh_value <= value_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
        r_sh_lz    <= lz_suppress;
        r_pending  <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign digit_tick = r_digit_tick;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
// ============================================================================
// tb_seven_segment_scan_driver
//   Directed and randomized stimulus against a cycle-count based display model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_driver;

  localparam int DIGITS = 4;
  localparam int RD     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  dp_in, blank_in;
  logic        lz_suppress, load;
  logic [3:0]  an, an_nh;
  logic [7:0]  seg, seg_nh;
  logic        digit_tick, frame_tick, pending;
  logic        dt_nh, ft_nh, pend_nh;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .HEX_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .load(load), .an(an), .seg(seg),
    .digit_tick(digit_tick), .frame_tick(frame_tick), .pending(pending)
  );

  seven_segment_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .HEX_EN(1'b0)) dut_nohex (
    .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .load(load), .an(an_nh), .seg(seg_nh),
    .digit_tick(dt_nh), .frame_tick(ft_nh), .pending(pend_nh)
  );

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

  int n_cmp = 0;
  int n_err = 0;

  // Model: edge count since reset release decides slot/frame timing.
  int          m_t;
  logic        m_pend;
  logic [15:0] m_val, m_sval;
  logic [3:0]  m_dp, m_sdp, m_blank, m_sblank;
  logic        m_lz, m_slz;
  logic [3:0]  e_an;
  logic [7:0]  e_seg, e_seg_nh;
  logic        e_dt, e_ft;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d, input bit hex);
    logic [3:0] nib;
    logic [6:0] g;
    nib = 4'((m_val >> (4 * d)) & 16'hF);
    if (m_blank[d]) return 8'hFF;
    if (m_lz && d > 0 && (m_val >> (4 * d)) == 16'd0) g = 7'h7F;
    else if (!hex && nib > 4'd9)                       g = 7'h7F;
    else                                               g = seg_tab[nib];
    return {g, ~m_dp[d]};
  endfunction

  task automatic model_edge();
    int  d;
    bit  slot, frame;
    if (reset) begin
      m_t = 0; m_pend = 0;
      m_val = '0; m_dp = '0; m_blank = '1; m_lz = 0;
      m_sval = '0; m_sdp = '0; m_sblank = '0; m_slz = 0;
      e_an = 4'hF; e_seg = 8'hFF; e_seg_nh = 8'hFF; e_dt = 0; e_ft = 0;
    end else begin
      m_t++;
      slot  = (m_t % RD) == 0;
      d     = slot ? ((m_t / RD) - 1) % DIGITS : 0;
      frame = slot && (d == 0);
      if (frame) begin
        if (load) begin
          m_val = value_in; m_dp = dp_in; m_blank = blank_in; m_lz = lz_suppress;
        end else if (m_pend) begin
          m_val = m_sval; m_dp = m_sdp; m_blank = m_sblank; m_lz = m_slz;
        end
        m_pend = 0;
      end else if (load) begin
        m_sval = value_in; m_sdp = dp_in; m_sblank = blank_in; m_slz = lz_suppress;
        m_pend = 1;
      end
      e_dt = slot;
      e_ft = frame;
      if (slot) begin
        e_an     = ~(4'b0001 << d);
        e_seg    = exp_seg(d, 1'b1);
        e_seg_nh = exp_seg(d, 1'b0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("an",         16'(an),         16'(e_an));
    check("seg",        16'(seg),        16'(e_seg));
    check("seg_nohex",  16'(seg_nh),     16'(e_seg_nh));
    check("digit_tick", 16'(digit_tick), 16'(e_dt));
    check("frame_tick", 16'(frame_tick), 16'(e_ft));
    check("pending",    16'(pending),    16'(m_pend));
  endtask

  task automatic run(input int n);
    load = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz);
    value_in = v; dp_in = dp; blank_in = bl; lz_suppress = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; blank_in = '0; lz_suppress = 1'b0;
    step(); step();
    check("rst_an",      16'(an),      16'hF);
    check("rst_seg",     16'(seg),     16'hFF);
    check("rst_pending", 16'(pending), 16'h0);
    reset = 1'b0;
    run(20);

    do_load(16'h1234, 4'h0, 4'h0, 1'b0); run(20);
    do_load(16'h0070, 4'h0, 4'h0, 1'b1); run(20);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1); run(20);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0); step();
    do_load(16'h2222, 4'h0, 4'h0, 1'b0); run(20);
    // Line the load up with a frame edge to exercise the shadow bypass.
    while (((m_t + 1) % (RD * DIGITS)) != RD) step();
    do_load(16'h5678, 4'h0, 4'h0, 1'b0);
    check("bypass_pending", 16'(pending), 16'h0);
    run(20);
    do_load(16'h000A, 4'h0, 4'h0, 1'b0); run(20);
    do_load(16'h0008, 4'h1, 4'h0, 1'b0); run(20);
    do_load(16'h0008, 4'h1, 4'h1, 1'b0); run(20);

    do_load(16'h9999, 4'h0, 4'h0, 1'b0);
    step();
    reset = 1'b1; step();
    check("midrst_an",      16'(an),      16'hF);
    check("midrst_pending", 16'(pending), 16'h0);
    reset = 1'b0;
    run(40);

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 400) == 0;
      load        = ($urandom % 8) == 0;
      value_in    = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in       = 4'($urandom);
      blank_in    = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      lz_suppress = 1'($urandom);
      step();
    end
    reset = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Parametrised, time-multiplexed driver for a common-anode seven-segment display bank of `DIGITS` digits. It scans one digit per refresh slot and decodes 4-bit hex or decimal nibbles to active-low segments. Updates are double-buffered: new values are committed only at frame boundaries, so they never tear. The block sits between the datapath that produces numeric results and the board's anode and segment pins, replacing per-digit static decoders.

## Interface

Parameters:
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be at least 2.
- `HEX_EN`, default 1: 1 decodes A–F glyphs; 0 blanks nibbles greater than 9.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `value_in` in 4*DIGITS: nibble k drives digit k; digit 0 is least significant and rightmost.
- `dp_in` in DIGITS: 1 lights the decimal point of digit k.
- `blank_in` in DIGITS: 1 forces digit k dark, including its dp.
- `lz_suppress` in 1: enables leading-zero blanking.
- `load` in 1: one-cycle strobe that captures `value_in`, `dp_in`, `blank_in` and `lz_suppress` into the shadow register.
- `an` out DIGITS: active-low one-hot anode select.
- `seg` out 8: `seg[7:1]` = a..g active-low; `seg[0]` = dp active-low.
- `digit_tick` out 1: one-cycle pulse on each slot change.
- `frame_tick` out 1: one-cycle pulse when the scan wraps to digit 0.
- `pending` out 1: shadow holds data not yet committed.

## Operation

- **Prescaler:** counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV). The terminal count marks a "slot edge"; on it the counter returns to 0.
- **Digit index:** advances at each slot edge and wraps from DIGITS-1 to 0. The wrap is a "frame edge".
- **Reset value of index:** DIGITS-1, so the first slot edge after reset is a frame edge.
- **Commit:** at a frame edge with `pending`=1, the active register takes the shadow and `pending` clears.
  - `load` on the same cycle as a frame edge bypasses the shadow: `value_in` etc. commit directly and `pending` stays 0.
- **Shadow writes:**
  - `load` at any other cycle writes the shadow and sets `pending`.
  - Repeated loads before a commit overwrite the shadow; last wins.
- **Digit decode, decimal 0–9** (`seg[7:1]`): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- **Digit decode, A–F** (HEX_EN=1): 0001000, 1100000, 0110001, 1000010, 0110000, 0111000. With HEX_EN=0, A–F give 1111111.
- **Leading-zero suppression:** with active `lz_suppress`=1, digit k (k>0) is blanked if its nibble and every higher nibble are 0. Digit 0 is never suppressed. dp of a suppressed digit still follows `dp_in`.
- **Blanking:** `blank_in` blanking overrides everything; the digit outputs `seg`=8'hFF.
- **Outputs:** `an` and `seg` are registered and change only at slot edges (or reset). They present the decoding of the new index from the post-commit active data.
- **DIGITS=1:** `an` is 1'b0 after the first edge, and every slot edge is also a frame edge.

## Timing

- **Reset state:** counter 0, index DIGITS-1, `an`=all ones, `seg`=8'hFF, `digit_tick`=0, `frame_tick`=0, `pending`=0, active value 0, active blank all ones, shadow cleared.
- **Reset mid-scan:** all reset values apply on the next edge. An uncommitted load is discarded.
- **First slot edge:** occurs on the REFRESH_DIV-th rising edge after `reset` deasserts. `an`, `seg`, `digit_tick` and `frame_tick` update on that same edge.
- **Tick pulses:** `digit_tick` is high for exactly one cycle per REFRESH_DIV cycles. `frame_tick` is high on every DIGITS-th `digit_tick`.
- **Load to display:**
  - `pending` rises the cycle after `load`.
  - Worst-case latency to visible change is DIGITS*REFRESH_DIV cycles plus one slot.
- **`load` during `reset`:** ignored.

## Test plan

(DIGITS=4, REFRESH_DIV=4 unless stated.)
- **Reset, no load:** release reset → at edge 4, `an`=1110, `seg`=8'hFF, `digit_tick`=1, `frame_tick`=1. `an` then rotates 1101, 1011, 0111, 1110 every 4 cycles.
- **Basic load:** load 16'h1234, `dp_in`=0 mid-frame → `pending`=1 until the next `frame_tick`. Then digits 0..3 show `seg` 8'h99, 8'h0D, 8'h25, 8'h9F.
- **Leading-zero suppression:** load 16'h0070, `lz_suppress`=1 → digit0 8'h03, digit1 8'h1F, digits 2 and 3 8'hFF. Load 16'h0000 → only digit0 shows 8'h03.
- **Last-load-wins and bypass:** two loads (16'h1111 then 16'h2222) in one frame → only 2222 is ever displayed. A load coinciding with `frame_tick` displays immediately and `pending` stays 0.
- **Hex, dp and blank:** nibble A with HEX_EN=1 → 8'h11; with HEX_EN=0 → 8'hFF. `dp_in[0]`=1 on digit 0 = 8 → 8'h00. `blank_in[0]`=1 → 8'hFF.
- **Reset mid-operation:** assert `reset` with `pending`=1 mid-slot → next edge `an`=1111, `seg`=8'hFF, `pending`=0. After release the display stays dark.
